// File: rtl/discus_loader.sv
// discus_loader -- byte-stream program loader for the discus CPU.
//
// Parses load frames arriving on a valid/ready byte stream and writes their
// payload into discus program memory through the snoop port. The CPU is
// held in reset until a frame completes successfully.
//
// Frame: 0x5A (SYNC), ADDR (base address), COUNT (N, 0 means 256),
//        N data bytes, then a checksum byte when checksumming is built in.
//
// Optional feature: define DISCUS_LOADER_CHECKSUM_EN to add a trailing
// checksum byte (sum of ADDR, COUNT and data bytes, mod 256). Without it
// there is no CSUM state and error is tied to 0.
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous active-high reset
//   in_data   in   [7:0] load-stream byte
//   in_valid  in   in_data holds a byte
//   in_ready  out  loader accepts a byte (transfer when valid & ready)
//   snoopa    out  [7:0] program-memory write address
//   snoopd    out  [7:0] program-memory write data
//   snoopp    out  write strobe, one cycle per byte
//   snoopm    out  snoop mode, always 0 (write)
//   cpu_reset out  holds discus in reset while high
//   busy      out  a load frame is in progress
//   error     out  last frame failed its checksum
module discus_loader (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] snoopa,
  output logic [7:0] snoopd,
  output logic       snoopp,
  output logic       snoopm,
  output logic       cpu_reset,
  output logic       busy,
  output logic       error
);

  localparam logic [7:0] SYNC_BYTE = 8'h5A;

`ifdef DISCUS_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_COUNT = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_COUNT = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4
  } state_t;
`endif

  state_t     state_r;
  state_t     state_s;
  logic       accept_s;
  logic       sync_s;
  logic       last_s;
  logic [7:0] addr_r;
  logic [8:0] rem_r;
  logic [7:0] snoopa_r;
  logic [7:0] snoopd_r;
  logic       cpu_reset_r;

  assign accept_s = in_valid & in_ready;
  assign sync_s   = accept_s & (in_data == SYNC_BYTE);
  // Remaining still counts the byte being written, so 1 means this is the last one.
  assign last_s   = (rem_r == 9'd1);

`ifdef DISCUS_LOADER_CHECKSUM_EN
  logic [7:0] csum_r;
  logic       error_r;
  logic       csum_ok_s;

  assign csum_ok_s = (in_data == csum_r);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (sync_s) state_s = S_ADDR;
        else        state_s = S_IDLE;
      end
      S_ADDR: begin
        if (accept_s) state_s = S_COUNT;
        else          state_s = S_ADDR;
      end
      S_COUNT: begin
        if (accept_s) state_s = S_DATA;
        else          state_s = S_COUNT;
      end
      S_DATA: begin
        if (accept_s) state_s = S_WRITE;
        else          state_s = S_DATA;
      end
      S_WRITE: begin
        if (!last_s) state_s = S_DATA;
`ifdef DISCUS_LOADER_CHECKSUM_EN
        else         state_s = S_CSUM;
`else
        else         state_s = S_IDLE;
`endif
      end
`ifdef DISCUS_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept_s) state_s = S_IDLE;
        else          state_s = S_CSUM;
      end
`endif
      default: state_s = S_IDLE;
    endcase
  end

  // State-decoded outputs, forced quiet while reset is high
  always_comb begin
    in_ready = 1'b0;
    snoopp   = 1'b0;
    busy     = 1'b0;
    if (reset) begin
      in_ready = 1'b0;
      snoopp   = 1'b0;
      busy     = 1'b0;
    end else begin
      in_ready = (state_r != S_WRITE);
      snoopp   = (state_r == S_WRITE);
      busy     = (state_r != S_IDLE);
    end
  end

  assign snoopm    = 1'b0;
  assign snoopa    = snoopa_r;
  assign snoopd    = snoopd_r;
  assign cpu_reset = cpu_reset_r | reset;

  // Address / remaining counters and the snoop write registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r   <= 8'h00;
      rem_r    <= 9'd0;
      snoopa_r <= 8'h00;
      snoopd_r <= 8'h00;
    end else begin
      case (state_r)
        S_ADDR: begin
          if (accept_s) addr_r <= in_data;
        end
        S_COUNT: begin
          // A count byte of 0 stands for 256.
          if (accept_s) rem_r <= {(in_data == 8'h00), in_data};
        end
        S_DATA: begin
          // snoopa is a separate copy so it holds steady while addr_r advances.
          if (accept_s) begin
            snoopa_r <= addr_r;
            snoopd_r <= in_data;
          end
        end
        S_WRITE: begin
          addr_r <= addr_r + 8'd1;
          rem_r  <= rem_r - 9'd1;
        end
        default: begin
          addr_r <= addr_r;
        end
      endcase
    end
  end

  // CPU reset hold: set by reset or a new frame, released only on success
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_reset_r <= 1'b1;
    end else if ((state_r == S_IDLE) && sync_s) begin
      cpu_reset_r <= 1'b1;
`ifdef DISCUS_LOADER_CHECKSUM_EN
    end else if ((state_r == S_CSUM) && accept_s && csum_ok_s) begin
`else
    end else if ((state_r == S_WRITE) && last_s) begin
`endif
      cpu_reset_r <= 1'b0;
    end else begin
      cpu_reset_r <= cpu_reset_r;
    end
  end

`ifdef DISCUS_LOADER_CHECKSUM_EN
  // Running checksum over ADDR, COUNT and data bytes
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_r <= 8'h00;
    end else if ((state_r == S_IDLE) && sync_s) begin
      csum_r <= 8'h00;
    end else if (accept_s && ((state_r == S_ADDR) || (state_r == S_COUNT) ||
                              (state_r == S_DATA))) begin
      csum_r <= csum_r + in_data;
    end else begin
      csum_r <= csum_r;
    end
  end

  // Error flag: set on checksum mismatch, cleared by the next SYNC
  always_ff @(posedge clk) begin
    if (reset) begin
      error_r <= 1'b0;
    end else if ((state_r == S_IDLE) && sync_s) begin
      error_r <= 1'b0;
    end else if ((state_r == S_CSUM) && accept_s && !csum_ok_s) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

  assign error = error_r & ~reset;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_discus_loader.sv
// Self-checking bench for discus_loader. Frames are built at the byte level;
// the expected memory writes (address, data) are derived from the frame
// contents and queued, and a monitor compares every snoop strobe against
// the queue. Directed frames use hand-written expected writes.
module tb_discus_loader;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] snoopa;
  logic [7:0] snoopd;
  logic       snoopp;
  logic       snoopm;
  logic       cpu_reset;
  logic       busy;
  logic       error;

`ifdef DISCUS_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  discus_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .snoopa(snoopa), .snoopd(snoopd), .snoopp(snoopp),
    .snoopm(snoopm), .cpu_reset(cpu_reset), .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
    logic       last;
  } wr_t;

  wr_t        exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         hits[256];
  logic [7:0] fdata[256];
  logic       prev_p = 1'b0;
  logic       done_pend = 1'b0;
  wr_t        mon_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d, input logic last);
    wr_t w;
    w.a = a;
    w.d = d;
    w.last = last & ~CSUM_ON;
    exp_q.push_back(w);
  endtask

  // Monitor: every strobe must match the next expected write
  always @(negedge clk) begin
    chk("snoopm_zero", {31'd0, snoopm}, 32'd0);
    if (done_pend) begin
      chk("done_busy", {31'd0, busy}, 32'd0);
      chk("done_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      done_pend = 1'b0;
    end
    if (snoopp === 1'b1) begin
      chk("write_ready_low", {31'd0, in_ready}, 32'd0);
      chk("write_spacing", {31'd0, prev_p}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {31'd0, snoopp}, 32'd0);
      end else begin
        mon_w = exp_q.pop_front();
        chk("write_addr", {24'd0, snoopa}, {24'd0, mon_w.a});
        chk("write_data", {24'd0, snoopd}, {24'd0, mon_w.d});
        hits[mon_w.a] = hits[mon_w.a] + 1;
        if (mon_w.last) done_pend = 1'b1;
      end
    end
    prev_p = snoopp;
  end

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   guard;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
    end
    guard = 0;
    rdy = 1'b0;
    do begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      rdy = in_ready;
      @(posedge clk);
      guard++;
    end while (!rdy && guard < 8);
    if (!rdy) chk("accept_timeout", {31'd0, rdy}, 32'd1);
  endtask

  task automatic send_junk(input logic [7:0] b);
    send_byte(b);
    @(negedge clk);
    in_valid = 1'b0;
    chk("junk_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_idle(input logic exp_cr, input logic exp_err);
    int g;
    g = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (busy && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    chk("end_cpu_reset", {31'd0, cpu_reset}, {31'd0, exp_cr});
    chk("end_error", {31'd0, error}, {31'd0, exp_err});
    chk("writes_drained", exp_q.size(), 32'd0);
  endtask

  // Sends one frame with payload fdata[0..n-1]; model=1 queues the expected writes.
  task automatic send_frame(input logic [7:0] base, input int n, input bit model, input bit bad);
    logic [7:0] cnt;
    logic [7:0] sum;
    cnt = 8'(n);
    sum = base + cnt;
    for (int i = 0; i < n; i++) sum = sum + fdata[i];
    if (model) begin
      for (int i = 0; i < n; i++) push_wr(base + 8'(i), fdata[i], i == n - 1);
    end
    send_byte(8'h5A);
    @(negedge clk);
    in_valid = 1'b0;
    chk("sync_busy", {31'd0, busy}, 32'd1);
    chk("sync_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("sync_error", {31'd0, error}, 32'd0);
    send_byte(base);
    send_byte(cnt);
    for (int i = 0; i < n; i++) send_byte(fdata[i]);
    if (CSUM_ON) send_byte(bad ? sum + 8'd1 : sum);
    wait_idle(bad, bad);
  endtask

  task automatic random_frame();
    logic [7:0] j;
    int n;
    repeat ($urandom_range(0, 2)) begin
      j = 8'($urandom_range(0, 255));
      if (j == 8'h5A) j = 8'h00;
      send_junk(j);
    end
    n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++) fdata[i] = 8'($urandom_range(0, 255));
    send_frame(8'($urandom_range(0, 255)), n, 1'b1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int distinct;
    int maxhit;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 256; i++) hits[i] = 0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_snoopp", {31'd0, snoopp}, 32'd0);
    chk("rst_snoopa", {24'd0, snoopa}, 32'h00);
    chk("rst_snoopd", {24'd0, snoopd}, 32'h00);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Basic three-byte frame
    fdata[0] = 8'h98; fdata[1] = 8'h0C; fdata[2] = 8'h14;
    push_wr(8'h00, 8'h98, 1'b0);
    push_wr(8'h01, 8'h0C, 1'b0);
    push_wr(8'h02, 8'h14, 1'b1);
    send_frame(8'h00, 3, 1'b0, 1'b0);

    // Junk before SYNC is discarded
    send_junk(8'h11);
    send_junk(8'h22);
    fdata[0] = 8'hE8;
    push_wr(8'h10, 8'hE8, 1'b1);
    send_frame(8'h10, 1, 1'b0, 1'b0);

    // Address wrap
    fdata[0] = 8'h01; fdata[1] = 8'h02; fdata[2] = 8'h03;
    push_wr(8'hFE, 8'h01, 1'b0);
    push_wr(8'hFF, 8'h02, 1'b0);
    push_wr(8'h00, 8'h03, 1'b1);
    send_frame(8'hFE, 3, 1'b0, 1'b0);

    // Count 0 means 256: every location written exactly once
    for (int i = 0; i < 256; i++) hits[i] = 0;
    for (int i = 0; i < 256; i++) fdata[i] = 8'($urandom_range(0, 255));
    send_frame(8'h00, 256, 1'b1, 1'b0);
    distinct = 0;
    maxhit = 0;
    for (int i = 0; i < 256; i++) begin
      if (hits[i] > 0) distinct++;
      if (hits[i] > maxhit) maxhit = hits[i];
    end
    chk("full_distinct", distinct, 32'd256);
    chk("full_maxhit", maxhit, 32'd1);

    // Randomized frames
    repeat (20) random_frame();

`ifdef DISCUS_LOADER_CHECKSUM_EN
    fdata[0] = 8'h60;
    push_wr(8'h00, 8'h60, 1'b0);
    send_frame(8'h00, 1, 1'b0, 1'b0);
    push_wr(8'h00, 8'h60, 1'b0);
    send_frame(8'h00, 1, 1'b0, 1'b1);
    random_frame();
`endif

    // Reset in the middle of a frame
    fdata[0] = 8'($urandom_range(1, 255));
    fdata[1] = 8'($urandom_range(1, 255));
    fdata[2] = 8'($urandom_range(1, 255));
    push_wr(8'h00, fdata[0], 1'b0);
    push_wr(8'h01, fdata[1], 1'b0);
    send_byte(8'h5A);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(fdata[0]);
    send_byte(fdata[1]);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom_range(0, 255));
    end
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_snoopp", {31'd0, snoopp}, 32'd0);
    chk("mid_rst_snoopa", {24'd0, snoopa}, 32'h00);
    chk("mid_rst_snoopd", {24'd0, snoopd}, 32'h00);
    chk("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_error", {31'd0, error}, 32'd0);
    chk("mid_rst_drained", exp_q.size(), 32'd0);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom_range(0, 255));
      if (in_data == 8'h5A) in_data = 8'h00;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Recovery after the abandoned frame
    random_frame();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/discus_loader.md
DISCUS_LOADER -- requirements
Module: discus_loader

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit, a synchronous active-high reset.
REQ-003 The block SHALL have the port in_data, input, 8 bits, the incoming load-stream byte.
REQ-004 The block SHALL have the port in_valid, input, 1 bit; when high, in_data holds a byte.
REQ-005 The block SHALL have the port in_ready, output, 1 bit; when high, the loader accepts a byte. A byte transfers on a clk edge where in_valid and in_ready are both high.
REQ-006 The block SHALL have the port snoopa, output, 8 bits, the program-memory write address to the discus snoop port.
REQ-007 The block SHALL have the port snoopd, output, 8 bits, the program-memory write data.
REQ-008 The block SHALL have the port snoopp, output, 1 bit, the snoop write strobe; each cycle it is high writes snoopd to snoopa.
REQ-009 The block SHALL have the port snoopm, output, 1 bit, the snoop mode; it is constant 0 (write).
REQ-010 The block SHALL have the port cpu_reset, output, 1 bit, the reset into discus; when high, the CPU is held in reset.
REQ-011 The block SHALL have the port busy, output, 1 bit; high while a load frame is in progress.
REQ-012 The block SHALL have the port error, output, 1 bit; high after a failed load.

Function
REQ-013 The load frame SHALL be: a SYNC byte 0x5A, then an ADDR byte (base address), then a COUNT byte (N, where 0 means 256), then N data bytes, then a checksum byte if CHECKSUM_EN is defined.
REQ-014 The states SHALL be IDLE, ADDR, COUNT, DATA, WRITE and CSUM.
REQ-015 In IDLE, in_ready SHALL be 1; a non-0x5A byte is discarded; 0x5A moves to ADDR.
REQ-016 On 0x5A in IDLE, busy and cpu_reset SHALL be 1 and error 0 from the next cycle.
REQ-017 In ADDR, the accepted byte SHALL load the address counter, and the state moves to COUNT.
REQ-018 In COUNT, the accepted byte SHALL load the remaining counter (9 bits; 0 loads 256), and the state moves to DATA.
REQ-019 In DATA, an accepted byte SHALL latch into snoopd with snoopa equal to the address counter, and the state moves to WRITE.
REQ-020 In WRITE, the duration SHALL be exactly one cycle: snoopp=1 and in_ready=0.
REQ-021 On leaving WRITE, the address SHALL increment modulo 256 (0xFF wraps to 0x00) and the remaining counter SHALL decrement.
REQ-022 On leaving WRITE, the next state SHALL be DATA if remaining is nonzero, otherwise CSUM (CHECKSUM_EN) or completion.
REQ-023 snoopp SHALL be 0 in every state other than WRITE.
REQ-024 snoopa and snoopd SHALL hold their value outside WRITE.
REQ-025 In ADDR, COUNT, DATA and CSUM, in_ready SHALL be 1.
REQ-026 The throughput SHALL be at most one data byte per 2 cycles.
REQ-027 On completion (success), the block SHALL go to IDLE the next cycle with busy=0 and cpu_reset=0 from that cycle.
REQ-028 The byte value 0x5A SHALL have no special meaning outside IDLE.
REQ-029 If in_valid is low in any accepting state, the block SHALL hold its state indefinitely, with no timeout.
REQ-030 The address wrap SHALL be silent; N=256 SHALL write all locations exactly once.

Reset
REQ-031 While reset is high, the block SHALL force state=IDLE, in_ready=0, snoopp=0, snoopm=0, snoopa=0x00, snoopd=0x00, cpu_reset=1, busy=0, error=0 and checksum=0.
REQ-032 A reset mid-frame SHALL abandon the frame; partially written memory is left as is, and cpu_reset stays 1.
REQ-033 After reset, cpu_reset SHALL remain 1 until the first successful frame.

Configuration
REQ-034 With DISCUS_LOADER_CHECKSUM_EN defined, the block SHALL keep a running sum of ADDR, COUNT and all data bytes mod 256.
REQ-035 With DISCUS_LOADER_CHECKSUM_EN defined, after the last write the block SHALL accept one byte in CSUM.
REQ-036 In CSUM, on a match the block SHALL complete per REQ-027; on a mismatch it SHALL go to IDLE with busy=0, error=1 and cpu_reset=1, held until the next 0x5A.
REQ-037 Without DISCUS_LOADER_CHECKSUM_EN, the block SHALL contain no CSUM state and no checksum logic, and error SHALL be constant 0.

Verification
REQ-038 The bench SHALL cover: after reset, stream 5A 00 03 98 0C 14 -> snoopp pulses at (00,98), (01,0C), (02,14); cpu_reset falls the cycle after the third WRITE; busy 1->0.
REQ-039 The bench SHALL cover: bytes 11 22 then 5A 10 01 E8 -> 11 and 22 discarded; a single write (10,E8); no other snoopp pulses.
REQ-040 The bench SHALL cover: 5A FE 03 01 02 03 -> writes (FE,01), (FF,02), (00,03), confirming the address wrap.
REQ-041 The bench SHALL cover: 5A 00 00 followed by 256 bytes -> exactly 256 writes covering 00..FF once each; completes.
REQ-042 The bench SHALL cover (CHECKSUM_EN): 5A 00 01 60 then 61 -> completion, cpu_reset=0. The same frame with checksum 62 -> error=1, cpu_reset=1. A following valid frame clears error.
REQ-043 The bench SHALL cover: reset asserted after 2 of 3 data bytes, with in_valid toggled randomly -> all outputs at reset values, no further writes, cpu_reset=1.
